// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass and per-register pending-write scoreboard
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nx;
  logic [AW:0] cnt_nx;
  logic hit1, hit2;
  always_comb begin
    busy_nx = busy;
    if (wr_en && wr_addr != '0) busy_nx[wr_addr] = 1'b0;
    if (iss_en && iss_rd != '0) busy_nx[iss_rd] = 1'b1;
    if (flush) busy_nx = '0;
    cnt_nx = '0;
    for (int i = 0; i < NREGS; i++) cnt_nx = cnt_nx + (AW+1)'(busy_nx[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
      busy <= busy_nx;
      busy_cnt <= cnt_nx;
    end
  end
  assign hit1 = BYPASS && wr_en && wr_addr == rs1_addr;
  assign hit2 = BYPASS && wr_en && wr_addr == rs2_addr;
  assign rs1_data = (!rst_n || rs1_addr == '0) ? '0 : hit1 ? wr_data : regs[rs1_addr];
  assign rs2_data = (!rst_n || rs2_addr == '0) ? '0 : hit2 ? wr_data : regs[rs2_addr];
  assign rs1_busy = rst_n && !hit1 && busy[rs1_addr];
  assign rs2_busy = rst_n && !hit2 && busy[rs2_addr];
endmodule
